// File: rtl/tictactoe.sv
// Tic-tac-toe referee: enforces turn order, latches legal moves into a sticky
// board, and flags wins, draws and win LEDs for a switch/LED game board.
module tictactoe #(
    parameter int unsigned BLINK_LOG2 = 0
) (
    input  logic       clk,
    input  logic       rst1,
    input  logic       rst2,
    input  logic [8:0] player1,
    input  logic [8:0] player2,
    output logic       reset,
    output logic [8:0] p1out,
    output logic [8:0] p2out,
    output logic       p1win,
    output logic       p2win,
    output logic       led1win,
    output logic       led2win,
    output logic       done
);

    typedef enum logic [1:0] {
        StP1Turn,
        StP2Turn,
        StOver
    } state_e;

    state_e     state_q, state_d;
    logic [8:0] p1_d, p2_d;
    logic [8:0] occ, new1, new2;

    function automatic logic has_line(input logic [8:0] b);
        return (&b[8:6]) | (&b[5:3]) | (&b[2:0]) |
               (b[8] & b[5] & b[2]) | (b[7] & b[4] & b[1]) | (b[6] & b[3] & b[0]) |
               (b[8] & b[4] & b[0]) | (b[6] & b[4] & b[2]);
    endfunction

    function automatic logic exactly_one(input logic [8:0] v);
        return (v != 9'd0) && ((v & (v - 9'd1)) == 9'd0);
    endfunction

    assign reset = rst1 | rst2;
    assign occ   = p1out | p2out;
    assign new1  = player1 & ~occ;
    assign new2  = player2 & ~occ;
    assign p1win = has_line(p1out);
    assign p2win = has_line(p2out);
    assign done  = p1win | p2win | (occ == 9'h1FF);

    // A finished board is frozen: done takes priority over any pending move.
    always_comb begin
        state_d = state_q;
        p1_d    = p1out;
        p2_d    = p2out;
        unique case (state_q)
            StP1Turn: begin
                if (done) begin
                    state_d = StOver;
                end else if (exactly_one(new1)) begin
                    p1_d    = p1out | new1;
                    state_d = StP2Turn;
                end
            end
            StP2Turn: begin
                if (done) begin
                    state_d = StOver;
                end else if (exactly_one(new2)) begin
                    p2_d    = p2out | new2;
                    state_d = StP1Turn;
                end
            end
            StOver: begin
            end
            default: state_d = StP1Turn;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StP1Turn;
            p1out   <= 9'd0;
            p2out   <= 9'd0;
        end else begin
            state_q <= state_d;
            p1out   <= p1_d;
            p2out   <= p2_d;
        end
    end

    if (BLINK_LOG2 == 0) begin : g_steady
        assign led1win = p1win;
        assign led2win = p2win;
    end else begin : g_blink
        logic [BLINK_LOG2-1:0] cnt_q;

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end

        assign led1win = p1win & cnt_q[BLINK_LOG2-1];
        assign led2win = p2win & cnt_q[BLINK_LOG2-1];
    end

endmodule

// File: tb/tb_tictactoe.sv
// Bench for tictactoe: directed games plus random switch play, checked against
// a cell-ownership model of the game rules; a second instance exercises blinking.
module tb_tictactoe;

    logic       clk = 1'b0;
    logic       rst1, rst2;
    logic [8:0] player1, player2;

    logic       reset, p1win, p2win, led1win, led2win, done;
    logic [8:0] p1out, p2out;
    logic       b_reset, b_p1win, b_p2win, b_led1win, b_led2win, b_done;
    logic [8:0] b_p1out, b_p2out;

    int checks = 0;
    int errors = 0;
    int owner[9];
    int turn;
    int cyc;

    tictactoe #(.BLINK_LOG2(0)) dut (
        .clk(clk), .rst1(rst1), .rst2(rst2), .player1(player1), .player2(player2),
        .reset(reset), .p1out(p1out), .p2out(p2out), .p1win(p1win), .p2win(p2win),
        .led1win(led1win), .led2win(led2win), .done(done)
    );

    tictactoe #(.BLINK_LOG2(2)) dutb (
        .clk(clk), .rst1(rst1), .rst2(rst2), .player1(player1), .player2(player2),
        .reset(b_reset), .p1out(b_p1out), .p2out(b_p2out), .p1win(b_p1win),
        .p2win(b_p2win), .led1win(b_led1win), .led2win(b_led2win), .done(b_done)
    );

    always #5 clk = ~clk;

    function automatic logic [8:0] board(input int p);
        logic [8:0] b = '0;
        for (int i = 0; i < 9; i++) if (owner[i] == p) b[i] = 1'b1;
        return b;
    endfunction

    function automatic logic won(input int p);
        int l[24] = '{8, 7, 6, 5, 4, 3, 2, 1, 0, 8, 5, 2, 7, 4, 1, 6, 3, 0, 8, 4, 0, 6, 4, 2};
        for (int k = 0; k < 8; k++)
            if (owner[l[3*k]] == p && owner[l[3*k+1]] == p && owner[l[3*k+2]] == p)
                return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic full();
        for (int i = 0; i < 9; i++) if (owner[i] == 0) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic over();
        return won(1) || won(2) || full();
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 9; i++) owner[i] = 0;
        turn = 1;
        cyc  = 0;
    endtask

    task automatic model_step();
        logic [8:0] sw;
        int n, idx;
        cyc++;
        if (over()) return;
        sw  = (turn == 1) ? player1 : player2;
        n   = 0;
        idx = 0;
        for (int i = 0; i < 9; i++) begin
            if (sw[i] && owner[i] == 0) begin
                n++;
                idx = i;
            end
        end
        if (n == 1) begin
            owner[idx] = turn;
            turn = 3 - turn;
        end
    endtask

    task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        logic blink;
        blink = ((cyc >> 1) & 1) != 0;
        chk("reset", {8'd0, reset}, {8'd0, rst1 | rst2});
        chk("p1out", p1out, board(1));
        chk("p2out", p2out, board(2));
        chk("p1win", {8'd0, p1win}, {8'd0, won(1)});
        chk("p2win", {8'd0, p2win}, {8'd0, won(2)});
        chk("done", {8'd0, done}, {8'd0, over()});
        chk("led1win", {8'd0, led1win}, {8'd0, won(1)});
        chk("led2win", {8'd0, led2win}, {8'd0, won(2)});
        chk("blink_led1", {8'd0, b_led1win}, {8'd0, won(1) & blink});
        chk("blink_led2", {8'd0, b_led2win}, {8'd0, won(2) & blink});
    endtask

    // Called at a negedge or shortly after; ends exactly on the following negedge.
    task automatic step(input logic [8:0] a, input logic [8:0] b);
        player1 = a;
        player2 = b;
        @(posedge clk);
        model_step();
        #1;
        check_all();
        @(negedge clk);
    endtask

    // Assert one reset button between edges, hold across one posedge, release.
    task automatic do_reset(input bit use_rst2);
        if (use_rst2) rst2 = 1'b1;
        else rst1 = 1'b1;
        model_reset();
        #1;
        check_all();
        chk("reset_pulse", {8'd0, reset}, 9'd1);
        chk("reset_p1clr", p1out, 9'd0);
        @(negedge clk);
        rst1 = 1'b0;
        rst2 = 1'b0;
        #1;
        check_all();
    endtask

    initial begin
        logic [8:0] s1, s2;
        int r;
        rst1    = 1'b1;
        rst2    = 1'b0;
        player1 = '0;
        player2 = '0;
        model_reset();
        #1;
        check_all();
        @(negedge clk);
        rst1 = 1'b0;
        #1;
        check_all();

        // Row win for player 1
        step(9'b100000000, 9'b000000000);
        step(9'b100000000, 9'b000100000);
        step(9'b110000000, 9'b000100000);
        step(9'b110000000, 9'b000110000);
        step(9'b111000000, 9'b000110000);
        chk("t1_p1out", p1out, 9'b111000000);
        chk("t1_p2out", p2out, 9'b000110000);
        chk("t1_p1win", {8'd0, p1win}, 9'd1);
        chk("t1_done", {8'd0, done}, 9'd1);
        chk("t1_led1", {8'd0, led1win}, 9'd1);

        // Frozen after the game ends
        step(9'b100000000, 9'b000010000);
        step(9'b000000001, 9'b000000100);
        chk("t2_p1out", p1out, 9'b111000000);
        chk("t2_p2out", p2out, 9'b000110000);
        chk("t2_p1win", {8'd0, p1win}, 9'd1);
        do_reset(1'b0);

        // Turn order and illegal moves
        step(9'b000000000, 9'b000000001);
        chk("t3_offturn", p2out, 9'd0);
        step(9'b110000000, 9'b000000001);
        chk("t3_twobits", p1out, 9'd0);
        step(9'b100000000, 9'b000000001);
        step(9'b100000000, 9'b000000001);
        chk("t3_p2late", p2out, 9'b000000001);
        step(9'b100000001, 9'b000000001);
        chk("t3_steal", p1out, 9'b100000000);
        step(9'b000000000, 9'b000000000);
        chk("t3_lower", p1out, 9'b100000000);
        do_reset(1'b1);

        // Column win for player 2
        step(9'b100000000, 9'b000000000);
        step(9'b100000000, 9'b010000000);
        step(9'b101000000, 9'b010000000);
        step(9'b101000000, 9'b010010000);
        step(9'b101000100, 9'b010010000);
        step(9'b101000100, 9'b010010010);
        chk("t4_p2win", {8'd0, p2win}, 9'd1);
        chk("t4_p1win", {8'd0, p1win}, 9'd0);
        chk("t4_done", {8'd0, done}, 9'd1);
        do_reset(1'b0);

        // Draw: P1 8,6,3,1,5 / P2 7,4,2,0
        s1 = '0;
        s2 = '0;
        s1[8] = 1'b1; step(s1, s2);
        s2[7] = 1'b1; step(s1, s2);
        s1[6] = 1'b1; step(s1, s2);
        s2[4] = 1'b1; step(s1, s2);
        s1[3] = 1'b1; step(s1, s2);
        s2[2] = 1'b1; step(s1, s2);
        s1[1] = 1'b1; step(s1, s2);
        s2[0] = 1'b1; step(s1, s2);
        s1[5] = 1'b1; step(s1, s2);
        chk("t5_done", {8'd0, done}, 9'd1);
        chk("t5_nowin", {7'd0, p1win, p2win}, 9'd0);

        // Mid-game reset via rst2, then player 1 moves first
        do_reset(1'b0);
        step(9'b000010000, 9'b000000000);
        step(9'b000010000, 9'b000000001);
        do_reset(1'b1);
        step(9'b000000000, 9'b000000010);
        chk("t6_p2wait", p2out, 9'd0);
        step(9'b000000100, 9'b000000010);
        chk("t6_p1first", p1out, 9'b000000100);

        // Random play
        s1 = player1;
        s2 = player2;
        for (int n = 0; n < 600; n++) begin
            r = $urandom_range(0, 99);
            if (r < 3 || (over() && r < 25)) begin
                do_reset(r[0]);
                s1 = '0;
                s2 = '0;
            end else begin
                r = $urandom_range(0, 99);
                if (r < 60) s1 = s1 | (9'd1 << $urandom_range(0, 8));
                else if (r < 80) s1 = 9'($urandom) & 9'h1FF;
                else if (r < 90) s1 = '0;
                r = $urandom_range(0, 99);
                if (r < 60) s2 = s2 | (9'd1 << $urandom_range(0, 8));
                else if (r < 80) s2 = 9'($urandom) & 9'h1FF;
                else if (r < 90) s2 = '0;
                step(s1, s2);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
